// File: rtl/baud_tick_controller.sv
// UART oversampling tick controller: programmable clock divider feeding a per-bit
// oversample counter, with a valid/ready divisor update applied on tick boundaries.
`timescale 1ns/1ps
module baud_tick_controller #(
  parameter int NB_DIV      = 10,
  parameter int DEFAULT_DIV = 163,
  parameter int OVERSAMPLE  = 16,
  parameter int NB_OS       = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic              i_cfg_valid,
  input  logic [NB_DIV-1:0] i_cfg_div,
  output logic              o_cfg_ready,
  output logic              o_cfg_err,
  input  logic              i_rx_resync,
  output logic              o_tick,
  output logic              o_mid_strobe,
  output logic              o_bit_strobe,
  output logic [NB_DIV-1:0] o_div
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [NB_DIV-1:0] DEF_DIV_C = NB_DIV'(DEFAULT_DIV);
  localparam logic [NB_DIV-1:0] MIN_DIV_C = NB_DIV'(2);
  localparam logic [NB_OS-1:0]  OS_MID_C  = NB_OS'(OVERSAMPLE / 2 - 1);
  localparam logic [NB_OS-1:0]  OS_LAST_C = NB_OS'(OVERSAMPLE - 1);

  state_t              state_r;
  logic [NB_DIV-1:0]   div_r;
  logic [NB_DIV-1:0]   pend_r;
  logic [NB_DIV-1:0]   cnt_r;
  logic [NB_OS-1:0]    os_cnt_r;
  logic                ready_r;
  logic                err_r;
  logic                tick_r;
  logic                mid_r;
  logic                bit_r;

  logic                accept_s;
  logic                div_ok_s;
  logic                boundary_s;
  logic [NB_DIV-1:0]   cnt_inc_s;
  logic [NB_OS-1:0]    os_inc_s;

  // Request qualification and counter decode shared by the state machine.
  always_comb begin
    accept_s   = i_cfg_valid & ready_r;
    div_ok_s   = (i_cfg_div >= MIN_DIV_C);
    boundary_s = (cnt_r == (div_r - NB_DIV'(1)));
    cnt_inc_s  = cnt_r + NB_DIV'(1);
    os_inc_s   = os_cnt_r + NB_OS'(1);
  end

  // Controller state, divisor registers, phase counters and registered strobes.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r  <= ST_IDLE;
      div_r    <= DEF_DIV_C;
      pend_r   <= NB_DIV'(0);
      cnt_r    <= NB_DIV'(0);
      os_cnt_r <= NB_OS'(0);
      ready_r  <= 1'b1;
      err_r    <= 1'b0;
      tick_r   <= 1'b0;
      mid_r    <= 1'b0;
      bit_r    <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      mid_r  <= 1'b0;
      bit_r  <= 1'b0;
      err_r  <= accept_s & ~div_ok_s;
      case (state_r)
        ST_IDLE: begin
          cnt_r    <= NB_DIV'(0);
          os_cnt_r <= NB_OS'(0);
          ready_r  <= 1'b1;
          if (accept_s && div_ok_s) begin
            div_r <= i_cfg_div;
          end
          if (i_enable) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN, ST_PEND: begin
          if (!i_enable) begin
            // A waiting divisor is committed rather than dropped when going idle.
            state_r  <= ST_IDLE;
            ready_r  <= 1'b1;
            cnt_r    <= NB_DIV'(0);
            os_cnt_r <= NB_OS'(0);
            if (state_r == ST_PEND) begin
              div_r <= pend_r;
            end else if (accept_s && div_ok_s) begin
              div_r <= i_cfg_div;
            end
          end else begin
            if (i_rx_resync) begin
              cnt_r    <= NB_DIV'(0);
              os_cnt_r <= NB_OS'(0);
            end else if (boundary_s) begin
              cnt_r    <= NB_DIV'(0);
              os_cnt_r <= os_inc_s;
              tick_r   <= 1'b1;
              mid_r    <= (os_cnt_r == OS_MID_C);
              bit_r    <= (os_cnt_r == OS_LAST_C);
            end else begin
              cnt_r <= cnt_inc_s;
            end
            if (state_r == ST_PEND) begin
              if (i_rx_resync || boundary_s) begin
                div_r   <= pend_r;
                state_r <= ST_RUN;
                ready_r <= 1'b1;
              end
            end else if (accept_s && div_ok_s) begin
              pend_r  <= i_cfg_div;
              state_r <= ST_PEND;
              ready_r <= 1'b0;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ready_r  <= 1'b1;
          cnt_r    <= NB_DIV'(0);
          os_cnt_r <= NB_OS'(0);
        end
      endcase
    end
  end

  assign o_cfg_ready  = ready_r;
  assign o_cfg_err    = err_r;
  assign o_tick       = tick_r;
  assign o_mid_strobe = mid_r;
  assign o_bit_strobe = bit_r;
  assign o_div        = div_r;

endmodule
